functional_unit_arbiter: RTL and testbench
==========================================

// Module: functional_unit_arbiter
// PURPOSE
//  Shares one pipelined 64-bit vector functional unit among NUM_REQ issue sources (lanes/sequencers).
//  Round-robin grant with optional multi-beat lock: a requester keeps the unit until its last beat.
//  Tracks in-flight beats in a tag pipeline and returns each result to its originating requester.
//  Sits between the vector issue logic and the functional_unit_interface common modport inputs.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  FU_LATENCY  3   fixed cycles from accepted issue to fu_vd valid (>=1)
//  OP_WIDTH    16  width of packed op/control word forwarded to the unit
// PORTS
//  clock       in   1            clock
//  reset_n     in   1            asynchronous active-low reset
//  req_valid   in   NUM_REQ      per-requester beat valid
//  req_last    in   NUM_REQ      beat is last of its group (1 for single-beat ops)
//  req_op      in   NUM_REQ*16   per-requester op word, slice i = [i*16 +: 16]
//  req_vs2     in   NUM_REQ*64   per-requester vs2 operand
//  req_vs1     in   NUM_REQ*64   per-requester vs1 operand
//  req_ready   out  NUM_REQ      beat accepted this cycle (one-hot or zero)
//  fu_valid    out  1            beat presented to unit
//  fu_ready    in   1            unit accepts beat
//  fu_op       out  16           selected op word
//  fu_vs2      out  64           selected vs2
//  fu_vs1      out  64           selected vs1
//  fu_vd       in   64           unit result, valid FU_LATENCY cycles after accept
//  rsp_valid   out  NUM_REQ      one-hot result strobe to owning requester
//  rsp_vd      out  64           result data (registered copy of fu_vd)
//  busy        out  1            locked or any beat in flight
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr=0, owner=0, tag pipe valid bits all 0, rsp_valid=0, rsp_vd=0, busy=0.
//    Reset mid-operation discards in-flight beats; no rsp_valid after reset deassertion.
//  - Grant (combinational): IDLE -> first req_valid[i] searching from rr_ptr upward, wrapping mod NUM_REQ;
//    LOCKED -> only owner eligible, others ignored even if valid.
//  - fu_valid = eligible request exists; fu_op/vs2/vs1 muxed from granted index (0 when none).
//  - fu_valid must not depend on fu_ready. req_ready[g] = fu_valid & fu_ready for granted g only.
//  - Accept = fu_valid & fu_ready. On accept with req_last=0: IDLE->LOCKED, owner=g.
//  - On accept with req_last=1: state->IDLE, rr_ptr=(g+1) mod NUM_REQ.
//  - rr_ptr changes only on a last-beat accept; unaccepted or locked cycles leave it unchanged.
//  - LOCKED with owner req_valid=0: unit idles (fu_valid=0), lock held; no timeout.
//  - Tag pipe: FU_LATENCY stages of {valid, index}; stage0 loads {accept, g} every cycle, shifts unconditionally.
//    Unit pipeline is never stalled by this block.
//  - Response: when last stage valid, next edge sets rsp_valid[index]=1, rsp_vd<=fu_vd.
//    Else rsp_valid=0, rsp_vd holds. Issue-to-rsp_valid latency = FU_LATENCY+1 cycles.
//  - Requesters accept responses unconditionally (no backpressure); results return in issue order.
//  - busy = (state==LOCKED) | any tag stage valid | any rsp_valid.
//  - Simultaneous issue and response on same requester in one cycle is legal and independent.
// TESTING
//  1 reset, req_valid=4'b1111, req_last=all1, fu_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
//    rsp_valid 0001,0010,0100,1000 starting 4 cycles after first grant.
//  2 req1 sends 3 beats (last on 3rd), req0/req2 valid throughout -> grants 1,1,1 then 2, then 0.
//    req0/2 req_ready=0 during lock.
//  3 fu_ready=0 for 5 cycles with req_valid=4'b0100 -> fu_valid=1, req_ready=0, rr_ptr constant.
//    Grant 2 on the cycle fu_ready rises.
//  4 single req3 issue, fu_vd=64'hDEAD_BEEF_0123_4567 at accept+3 -> rsp_valid=4'b1000.
//    rsp_vd matches at accept+4, busy falls next cycle.
//  5 reset_n asserted with 2 beats in flight and LOCKED -> outputs zero immediately.
//    No rsp_valid after release; grant restarts at req0.
//  6 LOCKED owner drops req_valid 3 cycles -> fu_valid=0, others blocked.
//    Owner resumes with last beat -> lock released, rr_ptr=owner+1.

Source files
------------

// File: rtl/functional_unit_arbiter.sv
// Round-robin arbiter sharing one pipelined 64-bit vector unit among NUM_REQ issue sources,
// with multi-beat locking and a tag pipeline that steers each result back to its requester.
module functional_unit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FU_LATENCY = 3,
  parameter int OP_WIDTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_op,
  input  logic [NUM_REQ*64-1:0]        req_vs2,
  input  logic [NUM_REQ*64-1:0]        req_vs1,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fu_valid,
  input  logic                         fu_ready,
  output logic [OP_WIDTH-1:0]          fu_op,
  output logic [63:0]                  fu_vs2,
  output logic [63:0]                  fu_vs1,
  input  logic [63:0]                  fu_vd,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [63:0]                  rsp_vd,
  output logic                         busy
);

  localparam int DATA_W = 64;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_owner;
  logic [IDX_W-1:0]      w_scan [NUM_REQ];
  logic                  w_gnt_vld;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_locked;
  logic [FU_LATENCY-1:0] r_tag_vld;
  logic [IDX_W-1:0]      r_tag_idx [FU_LATENCY];
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_vd;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] f_next_ptr(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] v;
    if (idx == IDX_W'(NUM_REQ - 1)) v = '0;
    else                            v = idx + 1'b1;
    return v;
  endfunction

  // Rotated search order starting at the round-robin pointer.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan[k] = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
    end
  end

  // Grant selection is gated by reset so the unit sees nothing while reset is held.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (reset_n) begin
      if (r_state == S_LOCKED) begin
        w_gnt_vld = req_valid[r_owner];
        w_gnt_idx = r_owner;
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (req_valid[w_scan[k]]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_scan[k];
          end
        end
      end
    end
  end

  assign w_accept = w_gnt_vld & fu_ready;
  assign w_last   = req_last[w_gnt_idx];

  always_comb begin
    fu_op  = '0;
    fu_vs2 = '0;
    fu_vs1 = '0;
    if (w_gnt_vld) begin
      fu_op  = req_op[int'(w_gnt_idx) * OP_WIDTH +: OP_WIDTH];
      fu_vs2 = req_vs2[int'(w_gnt_idx) * DATA_W +: DATA_W];
      fu_vs1 = req_vs1[int'(w_gnt_idx) * DATA_W +: DATA_W];
    end
  end

  assign fu_valid  = w_gnt_vld;
  assign req_ready = w_accept ? f_onehot(w_gnt_idx) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_last) w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_accept &&  w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_locked = (r_state == S_LOCKED);
    busy     = w_locked | (|r_tag_vld) | (|r_rsp_valid);
  end

  // Pointer only advances when a group finishes; owner is captured on a non-last beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else if (w_accept) begin
      if (w_last) r_rr_ptr <= f_next_ptr(w_gnt_idx);
      else        r_owner  <= w_gnt_idx;
    end
  end

  // ---- tag pipe: stage 0 captures the accept, later stages shift unconditionally ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_accept;
      for (int s = 1; s < FU_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    r_tag_idx[0] <= w_gnt_idx;
    for (int s = 1; s < FU_LATENCY; s++) begin
      r_tag_idx[s] <= r_tag_idx[s-1];
    end
  end

  // ---- response stage: registered result and one-hot strobe to the owning requester ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= '0;
      r_rsp_vd    <= '0;
    end else if (r_tag_vld[FU_LATENCY-1]) begin
      r_rsp_valid <= f_onehot(r_tag_idx[FU_LATENCY-1]);
      r_rsp_vd    <= fu_vd;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_vd    = r_rsp_vd;

endmodule

// File: tb/tb_functional_unit_arbiter.sv
// Self-checking bench for functional_unit_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (grant search, lock flag, queue of issued beats).
module tb_functional_unit_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int OPW = 16;

  logic              clock;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*OPW-1:0]  req_op;
  logic [N*64-1:0]   req_vs2;
  logic [N*64-1:0]   req_vs1;
  logic [N-1:0]      req_ready;
  logic              fu_valid;
  logic              fu_ready;
  logic [OPW-1:0]    fu_op;
  logic [63:0]       fu_vs2;
  logic [63:0]       fu_vs1;
  logic [63:0]       fu_vd;
  logic [N-1:0]      rsp_valid;
  logic [63:0]       rsp_vd;
  logic              busy;

  functional_unit_arbiter #(.NUM_REQ(N), .FU_LATENCY(LAT), .OP_WIDTH(OPW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_last(req_last), .req_op(req_op),
    .req_vs2(req_vs2), .req_vs1(req_vs1), .req_ready(req_ready),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op(fu_op),
    .fu_vs2(fu_vs2), .fu_vs1(fu_vs1), .fu_vd(fu_vd),
    .rsp_valid(rsp_valid), .rsp_vd(rsp_vd), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lock flag, owner, pointer, and a list of accepted beats dated by cycle.
  typedef struct {
    int          acc;
    int          idx;
    logic [63:0] vd;
  } ent_t;

  ent_t        q[$];
  bit          m_locked;
  int          m_owner;
  int          m_ptr;
  int          cyc;
  logic [N-1:0] m_rsp_vld;
  logic [63:0] m_rsp_vd;
  bit          next_vd_en;
  logic [63:0] next_vd;

  function automatic int exp_grant();
    if (!reset_n) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit exp_busy();
    return m_locked || (q.size() > 0);
  endfunction

  task automatic model_clear();
    q.delete();
    m_locked  = 0;
    m_owner   = 0;
    m_ptr     = 0;
    m_rsp_vld = '0;
    m_rsp_vd  = '0;
  endtask

  task automatic tick();
    int g;
    @(posedge clock);
    if (reset_n) begin
      g = exp_grant();
      if (g >= 0 && fu_ready) begin
        logic [63:0] v;
        v = next_vd_en ? next_vd : {$urandom(), $urandom()};
        next_vd_en = 0;
        q.push_back('{cyc, g, v});
        if (req_last[g]) begin
          m_locked = 0;
          m_ptr    = (g + 1) % N;
        end else begin
          m_locked = 1;
          m_owner  = g;
        end
      end
      cyc++;
      m_rsp_vld = '0;
      while (q.size() > 0 && q[0].acc < cyc - (LAT + 1)) void'(q.pop_front());
      if (q.size() > 0 && q[0].acc == cyc - (LAT + 1)) begin
        m_rsp_vld = N'(1) << q[0].idx;
        m_rsp_vd  = q[0].vd;
      end
    end else begin
      cyc++;
      model_clear();
    end
    #1;
    fu_vd = {$urandom(), $urandom()};
    foreach (q[i]) if (q[i].acc == cyc - LAT) fu_vd = q[i].vd;
  endtask

  task automatic rand_ops();
    req_op = {$urandom(), $urandom()};
    for (int i = 0; i < 2 * N; i++) begin
      req_vs2[i*32 +: 32] = $urandom();
      req_vs1[i*32 +: 32] = $urandom();
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    model_clear();
    req_valid = '0;
    req_last  = '0;
    fu_ready  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_tests++;
    if (rsp_valid !== '0 || rsp_vd !== '0) begin
      n_fail++; $display("FAIL reset_rsp rsp_valid=%b rsp_vd=%h required 0/0", rsp_valid, rsp_vd);
    end
    n_tests++;
    if (busy !== 1'b0 || fu_valid !== 1'b0 || req_ready !== '0) begin
      n_fail++; $display("FAIL reset_ctl busy=%b fu_valid=%b req_ready=%b required 0", busy, fu_valid, req_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int rr_seq[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_rsp;
    do_reset();
    fu_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      req_valid = (k < 5) ? 4'b1111 : 4'b0000;
      req_last  = 4'b1111;
      @(negedge clock);
      if (k < 5) begin
        n_tests++;
        if (req_ready !== (4'b0001 << rr_seq[k])) begin
          n_fail++; $display("FAIL rr_grant k=%0d got=%b required=%b", k, req_ready, 4'b0001 << rr_seq[k]);
        end
      end
      exp_rsp = (k >= 4 && k <= 8) ? (4'b0001 << ((k - 4) % 4)) : 4'b0000;
      n_tests++;
      if (rsp_valid !== exp_rsp || (k >= 4 && k <= 8 && rsp_vd !== m_rsp_vd)) begin
        n_fail++; $display("FAIL rr_rsp k=%0d got=%b/%h required=%b/%h", k, rsp_valid, rsp_vd, exp_rsp, m_rsp_vd);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    int g_seq[5] = '{1, 1, 1, 2, 0};
    do_reset();
    fu_ready  = 1'b1;
    req_valid = 4'b0001;
    req_last  = 4'b1111;
    tick();
    for (int j = 0; j < 5; j++) begin
      rand_ops();
      req_valid = (j < 3) ? 4'b0111 : 4'b0101;
      req_last  = (j >= 2) ? 4'b1111 : 4'b1101;
      @(negedge clock);
      n_tests++;
      if (req_ready !== (4'b0001 << g_seq[j])) begin
        n_fail++; $display("FAIL lock_grant j=%0d got=%b required=%b", j, req_ready, 4'b0001 << g_seq[j]);
      end
      if (j == 1 || j == 2) begin
        n_tests++;
        if (busy !== 1'b1 || fu_op !== req_op[1*OPW +: OPW]) begin
          n_fail++; $display("FAIL lock_hold j=%0d busy=%b fu_op=%h required busy=1 op=%h", j, busy, fu_op, req_op[1*OPW +: OPW]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fu_ready  = 1'b0;
    req_valid = 4'b0100;
    req_last  = 4'b1111;
    rand_ops();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_tests++;
      if (fu_valid !== 1'b1 || req_ready !== 4'b0000 || fu_vs1 !== req_vs1[2*64 +: 64]) begin
        n_fail++; $display("FAIL stall c=%0d fu_valid=%b req_ready=%b fu_vs1=%h required 1/0000/%h", c, fu_valid, req_ready, fu_vs1, req_vs1[2*64 +: 64]);
      end
      tick();
    end
    fu_ready = 1'b1;
    @(negedge clock);
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL stall_release got=%b required=0100", req_ready);
    end
    tick();
    req_valid = 4'b1111;
    @(negedge clock);
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL stall_next got=%b required=1000", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_single_rsp();
    do_reset();
    fu_ready   = 1'b1;
    req_valid  = 4'b1000;
    req_last   = 4'b1111;
    next_vd    = 64'hDEAD_BEEF_0123_4567;
    next_vd_en = 1;
    rand_ops();
    @(negedge clock);
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL single_issue got=%b required=1000", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      n_tests++;
      if (rsp_valid !== ((k == 4) ? 4'b1000 : 4'b0000) || busy !== (k <= 4)) begin
        n_fail++; $display("FAIL single_rsp k=%0d rsp_valid=%b busy=%b required=%b/%b", k, rsp_valid, busy, (k == 4) ? 4'b1000 : 4'b0000, k <= 4);
      end
      if (k == 4) begin
        n_tests++;
        if (rsp_vd !== 64'hDEAD_BEEF_0123_4567) begin
          n_fail++; $display("FAIL single_vd got=%h required=deadbeef01234567", rsp_vd);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    fu_ready  = 1'b1;
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    repeat (2) begin
      rand_ops();
      tick();
    end
    @(negedge clock);
    reset_n = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (rsp_valid !== '0 || busy !== 1'b0 || fu_valid !== 1'b0 || req_ready !== '0) begin
      n_fail++; $display("FAIL midop_reset rsp_valid=%b busy=%b fu_valid=%b req_ready=%b required all 0", rsp_valid, busy, fu_valid, req_ready);
    end
    repeat (2) tick();
    reset_n   = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      n_tests++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midop_ghost k=%0d rsp_valid=%b busy=%b required 0/0", k, rsp_valid, busy);
      end
      tick();
    end
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    @(negedge clock);
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midop_restart got=%b required=0001", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_owner_pause();
    do_reset();
    fu_ready  = 1'b1;
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    rand_ops();
    @(negedge clock);
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL pause_first got=%b required=0100", req_ready);
    end
    tick();
    req_valid = 4'b1011;
    req_last  = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_tests++;
      if (fu_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        n_fail++; $display("FAIL pause_block c=%0d fu_valid=%b req_ready=%b busy=%b required 0/0000/1", c, fu_valid, req_ready, busy);
      end
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clock);
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL pause_resume got=%b required=0100", req_ready);
    end
    tick();
    req_valid = 4'b1011;
    @(negedge clock);
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL pause_after got=%b required=1000", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0]   e_rr;
    logic [OPW-1:0] e_op;
    logic [63:0]    e_vs2, e_vs1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      req_valid = N'($urandom());
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 9) < 6);
      fu_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      g     = exp_grant();
      e_rr  = (g >= 0 && fu_ready) ? (N'(1) << g) : '0;
      e_op  = (g >= 0) ? req_op[g*OPW +: OPW] : '0;
      e_vs2 = (g >= 0) ? req_vs2[g*64 +: 64] : '0;
      e_vs1 = (g >= 0) ? req_vs1[g*64 +: 64] : '0;
      n_tests++;
      if (fu_valid !== (g >= 0) || req_ready !== e_rr) begin
        n_fail++; $display("FAIL rand_grant c=%0d fu_valid=%b req_ready=%b required %b/%b", c, fu_valid, req_ready, g >= 0, e_rr);
      end
      n_tests++;
      if (fu_op !== e_op || fu_vs2 !== e_vs2 || fu_vs1 !== e_vs1) begin
        n_fail++; $display("FAIL rand_mux c=%0d op=%h vs2=%h vs1=%h required %h/%h/%h", c, fu_op, fu_vs2, fu_vs1, e_op, e_vs2, e_vs1);
      end
      n_tests++;
      if (rsp_valid !== m_rsp_vld || rsp_vd !== m_rsp_vd) begin
        n_fail++; $display("FAIL rand_rsp c=%0d rsp_valid=%b rsp_vd=%h required %b/%h", c, rsp_valid, rsp_vd, m_rsp_vld, m_rsp_vd);
      end
      n_tests++;
      if (busy !== exp_busy()) begin
        n_fail++; $display("FAIL rand_busy c=%0d got=%b required=%b", c, busy, exp_busy());
      end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_op     = '0;
    req_vs2    = '0;
    req_vs1    = '0;
    fu_ready   = 1'b0;
    fu_vd      = '0;
    cyc        = 0;
    next_vd_en = 0;
    next_vd    = '0;
    model_clear();
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_single_rsp();
    test_reset_midop();
    test_owner_pause();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
